shared_sram_arbiter: RTL and testbench
======================================

Name: shared_sram_arbiter

Overview:
Responder end of the CPU's SRAM-like instruction and data ports. Arbitrates the fetch-stage and memory-stage requests onto one single-ported, synchronous-read memory. Routes each read result back to its requester one cycle after grant, and drives is_if_read, the fetch-side grant indication. A blocked fetch is held in a one-entry replay buffer, and a starvation counter guarantees forward progress for fetches.

Parameters:
ADDR_W, 16, memory word-address width; memory index = port addr[ADDR_W+1:2], higher bits ignored
STARVE_MAX, 3, consecutive data wins tolerated while a fetch waits before the fetch is forced to win

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
inst_sram_en  in  1  fetch request valid
inst_sram_we  in  4  fetch byte write enables; ignored, fetch is always a read
inst_sram_addr  in  32  fetch byte address
inst_sram_wdata  in  32  ignored
inst_sram_rdata  out  32  fetch read data
data_sram_en  in  1  data request valid
data_sram_we  in  4  data byte write enables; 0 = read
data_sram_addr  in  32  data byte address
data_sram_wdata  in  32  data write data
data_sram_rdata  out  32  data read data
is_if_read  out  1  fetch request granted this cycle
mem_en  out  1  memory access enable
mem_we  out  4  memory byte write enables
mem_addr  out  ADDR_W  memory word address
mem_wdata  out  32  memory write data
mem_rdata  in  32  memory read data, valid the cycle after mem_en with mem_we==0

Behaviour:
- State registers:
  - pend_valid/pend_addr: fetch replay buffer
  - gnt_q: NONE/INST/DATA, the owner of the read returning this cycle
  - starve_cnt: 0..STARVE_MAX, saturating
  - inst_hold / data_hold: 32-bit last-result registers
- Fetch candidate:
  - If inst_sram_en=1, use inst_sram_addr; a new request replaces any pending entry (newest wins, e.g. after a branch redirect).
  - Else, if pend_valid=1, use pend_addr.
  - Else, no fetch candidate.
- Grant, combinational:
  - Both candidates present: data wins unless starve_cnt==STARVE_MAX, in which case the fetch wins.
  - Only one candidate present: it wins.
- Memory drive, combinational:
  - mem_en=1 iff a grant is made.
  - mem_we = data_sram_we on a data grant, 4'b0 on a fetch grant.
  - mem_addr and mem_wdata come from the winner; mem_wdata=0 on a fetch grant.
- is_if_read = fetch candidate present AND fetch granted. It is 0 when there is no fetch candidate.
- Replay buffer:
  - Fetch candidate present but not granted → pend_valid<=1, pend_addr<=candidate address.
  - Fetch granted → pend_valid<=0.
- starve_cnt:
  - Increment, saturating at STARVE_MAX, when a fetch candidate is present and data is granted.
  - Clear when the fetch is granted or there is no fetch candidate.
- gnt_q next value:
  - INST on a fetch grant.
  - DATA on a data read grant (mem_we==0).
  - NONE on a data write or no grant.
- Return path, 1-cycle latency:
  - inst_sram_rdata = (gnt_q==INST) ? mem_rdata : inst_hold.
  - data_sram_rdata = (gnt_q==DATA) ? mem_rdata : data_hold.
  - On each edge, the hold register selected by gnt_q captures mem_rdata. Outputs are stable until that port's next read returns.
- Writes return nothing; data_hold is unchanged by a write.
- Simultaneous data write and fetch to the same word: the winner goes first. A fetch issued after the write reads the new data; no forwarding.
- Reset, synchronous, including mid-operation:
  - pend_valid=0, gnt_q=NONE, starve_cnt=0, inst_hold=0, data_hold=0.
  - While reset=1: mem_en=0, mem_we=0, is_if_read=0, inst_sram_rdata=0, data_sram_rdata=0.
  - Any in-flight return or pending fetch is discarded.

Decomposition:
- Shared package:
  - gnt_q encoding constants: GNT_NONE=2'd0, GNT_INST=2'd1, GNT_DATA=2'd2.
  - Default ADDR_W and STARVE_MAX.
- One natural sub-module, sram_rdata_return: gnt_q, the two hold registers and the output muxes.
- Arbitration, replay buffer and starvation counter stay in the top.

Test Plan:
- Fetch only, addr 0x80000000, mem word 0 = 0x02C00413 → is_if_read=1, mem_addr=0; next cycle inst_sram_rdata=0x02C00413, held on the following idle cycles.
- Fetch 0x80000004 and data read 0x1C same cycle → data granted, is_if_read=0, pend_valid=1; next cycle data_sram_rdata = mem word 7, replayed fetch of word 1 granted; inst_sram_rdata valid the cycle after.
- Fetch held while data reads issue every cycle, STARVE_MAX=3 → data granted 3 cycles, 4th cycle is_if_read=1, starve_cnt returns to 0.
- Pending fetch 0x80000008, then new inst_sram_en 0x80000040 while still blocked → pending replaced; memory sees word 16, never word 2.
- Data write we=4'b0011, wdata 0x0000BEEF to 0x10, then fetch of word 4 → mem_we=4'b0011 first cycle, gnt_q=NONE; fetch returns memory-updated value; data_sram_rdata unchanged.
- Reset asserted the cycle after a fetch grant → mem_en=0, inst_sram_rdata=0, pend_valid=0; first request after deassert behaves as from cold.

Source files
------------

// File: rtl/shared_sram_arbiter_pkg.sv
// Shared definitions for the instruction/data SRAM arbiter: default sizing
// and the encoding of the read-return owner.
package shared_sram_arbiter_pkg;

    // Default memory word-address width (memory index = byte addr[ADDR_W+1:2]).
    localparam int DEF_ADDR_W     = 16;
    // Default number of consecutive data wins tolerated while a fetch waits.
    localparam int DEF_STARVE_MAX = 3;

    // Owner of the synchronous-read result arriving in the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_INST = 2'd1,
        GNT_DATA = 2'd2
    } gnt_e;

    // Counter width able to hold 0..max_val, never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/shared_sram_arbiter_rdata_return.sv
// Read-return path: remembers who owns the in-flight read, steers the memory
// result to that port and keeps each port's last result stable in between.
module sram_rdata_return
    import shared_sram_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  gnt_e        gnt_d,
    input  logic [31:0] mem_rdata,
    output logic [31:0] inst_sram_rdata,
    output logic [31:0] data_sram_rdata
);

    gnt_e        gnt_q;
    logic [31:0] inst_hold_q;
    logic [31:0] data_hold_q;

    // Track the returning read's owner and latch its data into that port's hold register.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_q       <= GNT_NONE;
            inst_hold_q <= 32'd0;
            data_hold_q <= 32'd0;
        end else begin
            gnt_q <= gnt_d;
            if (gnt_q == GNT_INST) begin
                inst_hold_q <= mem_rdata;
            end
            if (gnt_q == GNT_DATA) begin
                data_hold_q <= mem_rdata;
            end
        end
    end

    // Live memory data in the return cycle, held data otherwise; forced to zero while in reset
    // so a read granted just before reset never leaks out.
    always_comb begin
        inst_sram_rdata = inst_hold_q;
        data_sram_rdata = data_hold_q;
        if (reset) begin
            inst_sram_rdata = 32'd0;
            data_sram_rdata = 32'd0;
        end else begin
            if (gnt_q == GNT_INST) begin
                inst_sram_rdata = mem_rdata;
            end
            if (gnt_q == GNT_DATA) begin
                data_sram_rdata = mem_rdata;
            end
        end
    end

endmodule

// File: rtl/shared_sram_arbiter.sv
// Arbitrates the CPU fetch and data SRAM ports onto one single-ported,
// synchronous-read memory. Data normally wins; a blocked fetch waits in a
// one-entry replay buffer and a saturating starvation counter eventually
// forces the fetch through.
module shared_sram_arbiter
    import shared_sram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              inst_sram_en,
    input  logic [3:0]        inst_sram_we,
    input  logic [31:0]       inst_sram_addr,
    input  logic [31:0]       inst_sram_wdata,
    output logic [31:0]       inst_sram_rdata,
    input  logic              data_sram_en,
    input  logic [3:0]        data_sram_we,
    input  logic [31:0]       data_sram_addr,
    input  logic [31:0]       data_sram_wdata,
    output logic [31:0]       data_sram_rdata,
    output logic              is_if_read,
    output logic              mem_en,
    output logic [3:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int CNT_W = cnt_width(STARVE_MAX);

    // The fetch port never writes, and address bits outside the word index are don't-care.
    logic unused_inputs;
    assign unused_inputs = ^{inst_sram_we, inst_sram_wdata,
                             inst_sram_addr[31:ADDR_W+2], inst_sram_addr[1:0],
                             data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    gnt_e              gnt_d;

    logic              fetch_vld;
    logic [ADDR_W-1:0] fetch_word;
    logic              fetch_win;
    logic              data_win;

    // Pick the fetch candidate (new request beats the replay entry), arbitrate, drive the
    // memory and work out the next replay/starvation/return-owner state.
    always_comb begin
        fetch_vld  = inst_sram_en | pend_valid_q;
        fetch_word = inst_sram_en ? inst_sram_addr[ADDR_W+1:2] : pend_addr_q;
        fetch_win  = fetch_vld & (~data_sram_en | (starve_q == CNT_W'(STARVE_MAX)));
        data_win   = data_sram_en & ~fetch_win;
        if (reset) begin
            fetch_win = 1'b0;
            data_win  = 1'b0;
        end

        mem_en     = fetch_win | data_win;
        mem_we     = data_win ? data_sram_we : 4'b0000;
        mem_addr   = data_win ? data_sram_addr[ADDR_W+1:2] : fetch_word;
        mem_wdata  = data_win ? data_sram_wdata : 32'd0;
        is_if_read = fetch_win;

        // Replay buffer: remember a blocked fetch, drop it once it is served.
        pend_valid_d = pend_valid_q;
        pend_addr_d  = pend_addr_q;
        if (fetch_win) begin
            pend_valid_d = 1'b0;
        end else if (fetch_vld) begin
            pend_valid_d = 1'b1;
            pend_addr_d  = fetch_word;
        end

        // Count data wins over a waiting fetch; any other outcome restarts the count.
        starve_d = '0;
        if (fetch_vld && data_win) begin
            starve_d = (starve_q == CNT_W'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
        end

        // Only reads produce a return next cycle; writes leave the owner empty.
        gnt_d = GNT_NONE;
        if (fetch_win) begin
            gnt_d = GNT_INST;
        end else if (data_win && (data_sram_we == 4'b0000)) begin
            gnt_d = GNT_DATA;
        end
    end

    // Arbitration state registers; reset discards any pending fetch.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            starve_q     <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            starve_q     <= starve_d;
        end
    end

    sram_rdata_return u_rdata_return (
        .clk             (clk),
        .reset           (reset),
        .gnt_d           (gnt_d),
        .mem_rdata       (mem_rdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_rdata (data_sram_rdata)
    );

endmodule

// File: tb/tb_shared_sram_arbiter.sv
// Directed bench for shared_sram_arbiter with a small byte-writable,
// synchronous-read memory model behind the memory port.
module tb_shared_sram_arbiter;

    localparam int ADDR_W = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              inst_sram_en;
    logic [3:0]        inst_sram_we;
    logic [31:0]       inst_sram_addr;
    logic [31:0]       inst_sram_wdata;
    logic [31:0]       inst_sram_rdata;
    logic              data_sram_en;
    logic [3:0]        data_sram_we;
    logic [31:0]       data_sram_addr;
    logic [31:0]       data_sram_wdata;
    logic [31:0]       data_sram_rdata;
    logic              is_if_read;
    logic              mem_en;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    logic [31:0] mem_arr [0:63];

    int n_checks = 0;
    int n_pass   = 0;

    shared_sram_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(3)) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_we    (data_sram_we),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .is_if_read      (is_if_read),
        .mem_en          (mem_en),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: word k holds 0xA000_0000|k except word 0; non-read cycles return a
    // poison value so a wrongly selected return shows up.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                mem_arr[i] <= 32'hA000_0000 | i;
            end
            mem_arr[0] <= 32'h02C0_0413;
            mem_rdata  <= 32'hDEAD_BEEF;
        end else if (mem_en && mem_we != 4'b0000) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) mem_arr[mem_addr[5:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            mem_rdata <= 32'hDEAD_BEEF;
        end else if (mem_en) begin
            mem_rdata <= mem_arr[mem_addr[5:0]];
        end else begin
            mem_rdata <= 32'hDEAD_BEEF;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ien, input logic [31:0] iaddr, input logic den,
                         input logic [3:0] dwe, input logic [31:0] daddr, input logic [31:0] dwdata);
        inst_sram_en    = ien;
        inst_sram_we    = 4'hF;
        inst_sram_addr  = iaddr;
        inst_sram_wdata = 32'h1234_5678;
        data_sram_en    = den;
        data_sram_we    = dwe;
        data_sram_addr  = daddr;
        data_sram_wdata = dwdata;
        $display("t=%0t txn: reset=%0b inst_en=%0b iaddr=%h data_en=%0b we=%b daddr=%h wdata=%h",
                 $time, reset, ien, iaddr, den, dwe, daddr, dwdata);
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        idle();
        step();
        step();

        // Requests during reset must not reach memory.
        drive(1'b1, 32'h8000_0000, 1'b1, 4'hF, 32'h10, 32'hFFFF_FFFF);
        #1;
        check_eq("rst_mem_en", mem_en, 0);
        check_eq("rst_mem_we", mem_we, 0);
        check_eq("rst_is_if_read", is_if_read, 0);
        check_eq("rst_inst_rdata", inst_sram_rdata, 0);
        check_eq("rst_data_rdata", data_sram_rdata, 0);
        step();
        reset = 1'b0;
        idle();
        #1;
        check_eq("cold_no_pending", mem_en, 0);
        step();

        // Fetch only from word 0.
        drive(1'b1, 32'h8000_0000, 1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        check_eq("t1_is_if_read", is_if_read, 1);
        check_eq("t1_mem_en", mem_en, 1);
        check_eq("t1_mem_addr", mem_addr, 0);
        check_eq("t1_mem_we", mem_we, 0);
        check_eq("t1_mem_wdata", mem_wdata, 0);
        step();
        check_eq("t1_inst_rdata", inst_sram_rdata, 32'h02C0_0413);
        idle();
        #1;
        check_eq("t1_idle_mem_en", mem_en, 0);
        step();
        check_eq("t1_inst_held", inst_sram_rdata, 32'h02C0_0413);

        // Fetch and data read collide; data wins, fetch replays next cycle.
        drive(1'b1, 32'h8000_0004, 1'b1, 4'd0, 32'h1C, 32'd0);
        #1;
        check_eq("t2_is_if_read", is_if_read, 0);
        check_eq("t2_mem_addr", mem_addr, 7);
        step();
        check_eq("t2_data_rdata", data_sram_rdata, 32'hA000_0007);
        check_eq("t2_inst_still_held", inst_sram_rdata, 32'h02C0_0413);
        idle();
        #1;
        check_eq("t2_replay_grant", is_if_read, 1);
        check_eq("t2_replay_addr", mem_addr, 1);
        step();
        check_eq("t2_inst_rdata", inst_sram_rdata, 32'hA000_0001);
        check_eq("t2_data_held", data_sram_rdata, 32'hA000_0007);

        // Starvation: three data wins, then the fetch is forced through.
        drive(1'b1, 32'h8000_0008, 1'b1, 4'd0, 32'h20, 32'd0);
        #1;
        check_eq("t3_c0_is_if_read", is_if_read, 0);
        check_eq("t3_c0_mem_addr", mem_addr, 8);
        for (int k = 1; k < 3; k++) begin
            step();
            check_eq("t3_data_rdata", data_sram_rdata, 32'hA000_0000 | (8 + k - 1));
            drive(1'b1, 32'h8000_0008, 1'b1, 4'd0, 32'h20 + 4 * k, 32'd0);
            #1;
            check_eq("t3_is_if_read", is_if_read, 0);
            check_eq("t3_mem_addr", mem_addr, 8 + k);
        end
        step();
        check_eq("t3_data_rdata_c2", data_sram_rdata, 32'hA000_000A);
        drive(1'b1, 32'h8000_0008, 1'b1, 4'd0, 32'h2C, 32'd0);
        #1;
        check_eq("t3_forced_fetch", is_if_read, 1);
        check_eq("t3_forced_addr", mem_addr, 2);
        step();
        check_eq("t3_inst_rdata", inst_sram_rdata, 32'hA000_0002);
        check_eq("t3_data_held", data_sram_rdata, 32'hA000_000A);
        // Counter restarted: data wins again over a new fetch.
        drive(1'b1, 32'h8000_000C, 1'b1, 4'd0, 32'h30, 32'd0);
        #1;
        check_eq("t3_cnt_cleared", is_if_read, 0);
        check_eq("t3_cnt_cleared_addr", mem_addr, 12);
        step();
        check_eq("t3_data_rdata_w12", data_sram_rdata, 32'hA000_000C);
        idle();
        #1;
        check_eq("t3_replay_grant", is_if_read, 1);
        check_eq("t3_replay_addr", mem_addr, 3);
        step();
        check_eq("t3_inst_rdata_w3", inst_sram_rdata, 32'hA000_0003);

        // Pending fetch replaced by a newer one while still blocked.
        drive(1'b1, 32'h8000_0008, 1'b1, 4'd0, 32'h0, 32'd0);
        #1;
        check_eq("t4_c0_is_if_read", is_if_read, 0);
        check_eq("t4_c0_mem_addr", mem_addr, 0);
        step();
        check_eq("t4_data_rdata_w0", data_sram_rdata, 32'h02C0_0413);
        drive(1'b1, 32'h8000_0040, 1'b1, 4'd0, 32'h4, 32'd0);
        #1;
        check_eq("t4_c1_is_if_read", is_if_read, 0);
        check_eq("t4_c1_mem_addr", mem_addr, 1);
        step();
        check_eq("t4_data_rdata_w1", data_sram_rdata, 32'hA000_0001);
        idle();
        #1;
        check_eq("t4_replay_grant", is_if_read, 1);
        check_eq("t4_replay_newest", mem_addr, 16);
        step();
        check_eq("t4_inst_rdata_w16", inst_sram_rdata, 32'hA000_0010);

        // Partial write beats a same-word fetch; the fetch then sees the new bytes.
        drive(1'b1, 32'h8000_0010, 1'b1, 4'b0011, 32'h10, 32'h0000_BEEF);
        #1;
        check_eq("t5_mem_we", mem_we, 4'b0011);
        check_eq("t5_mem_addr", mem_addr, 4);
        check_eq("t5_mem_wdata", mem_wdata, 32'h0000_BEEF);
        check_eq("t5_is_if_read", is_if_read, 0);
        step();
        check_eq("t5_data_unchanged", data_sram_rdata, 32'hA000_0001);
        check_eq("t5_inst_unchanged", inst_sram_rdata, 32'hA000_0010);
        idle();
        #1;
        check_eq("t5_fetch_grant", is_if_read, 1);
        check_eq("t5_fetch_addr", mem_addr, 4);
        check_eq("t5_fetch_we", mem_we, 0);
        check_eq("t5_fetch_wdata", mem_wdata, 0);
        step();
        check_eq("t5_inst_new_data", inst_sram_rdata, 32'hA000_BEEF);
        check_eq("t5_data_still", data_sram_rdata, 32'hA000_0001);

        // Reset right after a fetch grant discards the return.
        drive(1'b1, 32'h8000_0000, 1'b0, 4'd0, 32'd0, 32'd0);
        #1;
        check_eq("t6_fetch_grant", is_if_read, 1);
        step();
        reset = 1'b1;
        drive(1'b1, 32'h8000_0004, 1'b1, 4'hF, 32'h8, 32'hFFFF_FFFF);
        #1;
        check_eq("t6_rst_inst_rdata", inst_sram_rdata, 0);
        check_eq("t6_rst_data_rdata", data_sram_rdata, 0);
        check_eq("t6_rst_mem_en", mem_en, 0);
        check_eq("t6_rst_mem_we", mem_we, 0);
        check_eq("t6_rst_is_if_read", is_if_read, 0);
        step();
        reset = 1'b0;
        idle();
        #1;
        check_eq("t6_no_pending", mem_en, 0);
        check_eq("t6_inst_hold_clr", inst_sram_rdata, 0);
        check_eq("t6_data_hold_clr", data_sram_rdata, 0);
        drive(1'b1, 32'h8000_0004, 1'b1, 4'd0, 32'h8, 32'd0);
        #1;
        check_eq("t6_cold_data_wins", is_if_read, 0);
        check_eq("t6_cold_addr", mem_addr, 2);
        step();
        check_eq("t6_cold_data_rdata", data_sram_rdata, 32'hA000_0002);
        idle();
        #1;
        check_eq("t6_cold_replay", is_if_read, 1);
        check_eq("t6_cold_replay_addr", mem_addr, 1);
        step();
        check_eq("t6_cold_inst_rdata", inst_sram_rdata, 32'hA000_0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
